sim_refill_merger: RTL and testbench

- Parametrised replacement for the simulation-top instruction-refill glue. The previous glue combinationally ORed bootrom and L2 responses.
- Routes each icache refill request to one of NUM_SRC behavioural memory models, chosen by address region.
- Buffers each source's responses in a per-source FIFO and merges them round-robin into a single response stream.
- Enforces an outstanding-request limit and raises sticky error flags on overflow, spurious response, or timeout.

---
 rtl/sim_refill_pkg.sv | 15 +
 rtl/sim_refill_merger_if.sv | 39 +++
 rtl/sim_refill_fifo.sv | 48 ++++
 rtl/sim_refill_merger.sv | 152 +++++++++++++++
 tb/tb_sim_refill_merger.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_refill_pkg.sv
// Shared constants for the simulation-top refill merger: default region map and source ids.
package sim_refill_pkg;

  typedef enum logic [0:0] {
    SRC_BROM = 1'b0,
    SRC_L2   = 1'b1
  } src_e;

  localparam int DEF_NUM_SRC = 2;
  localparam int DEF_ADDR_W  = 40;

  // Entry 0 (bootrom) must stay at address 0 so every address decodes somewhere.
  localparam logic [DEF_NUM_SRC-1:0][DEF_ADDR_W-1:0] DEF_SRC_BASE = {40'h00_0001_0000, 40'h0};

endpackage

// File: rtl/sim_refill_merger_if.sv
// Request / per-source response / merged response bundle of the refill merger.
interface sim_refill_merger_if #(
  parameter int NUM_SRC   = 2,
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 128,
  parameter int MAX_OUTST = 4
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  logic                      req_valid_i;
  logic [ADDR_W-1:0]         req_addr_i;
  logic                      req_ready_o;
  logic [NUM_SRC-1:0]        src_req_valid_o;
  logic [ADDR_W-1:0]         src_req_addr_o;
  logic [NUM_SRC-1:0]        src_resp_valid_i;
  logic [NUM_SRC*DATA_W-1:0] src_resp_data_i;
  logic                      resp_valid_o;
  logic [DATA_W-1:0]         resp_data_o;
  logic [SRC_W-1:0]          resp_src_o;
  logic [OUT_W-1:0]          outst_o;
  logic                      err_overflow_o;
  logic                      err_spurious_o;
  logic                      err_timeout_o;
  logic [SRC_W-1:0]          err_src_o;

  modport slave (
    input  req_valid_i, req_addr_i, src_resp_valid_i, src_resp_data_i,
    output req_ready_o, src_req_valid_o, src_req_addr_o, resp_valid_o, resp_data_o,
           resp_src_o, outst_o, err_overflow_o, err_spurious_o, err_timeout_o, err_src_o
  );

  modport master (
    output req_valid_i, req_addr_i, src_resp_valid_i, src_resp_data_i,
    input  req_ready_o, src_req_valid_o, src_req_addr_o, resp_valid_o, resp_data_o,
           resp_src_o, outst_o, err_overflow_o, err_spurious_o, err_timeout_o, err_src_o
  );

endinterface

// File: rtl/sim_refill_fifo.sv
// Per-source response FIFO, power-of-two depth; a push into a full FIFO is legal when it pops in
// the same cycle. No backpressure of its own: the caller only pushes when there is room.
module sim_refill_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic              tb_clk,
  input  logic              tb_rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  always_ff @(posedge tb_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/sim_refill_merger.sv
// Routes refill requests by address region and merges per-source responses round-robin; 2-cycle
// source-to-response latency. Sources are never backpressured; a response into a full FIFO is dropped.
module sim_refill_merger
  import sim_refill_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int ADDR_W     = 40,
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 4,
  parameter logic [NUM_SRC-1:0][ADDR_W-1:0] SRC_BASE = DEF_SRC_BASE,
  parameter int TIMEOUT    = 1024
) (
  input logic           tb_clk,
  input logic           tb_rstn,
  sim_refill_merger_if.slave bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic                 accept;
  logic [SRC_W-1:0]     dec;
  logic [OUT_W-1:0]     outst;
  logic [SRC_W-1:0]     ptr;
  logic                 grant_vld;
  logic [SRC_W-1:0]     grant;
  logic [NUM_SRC-1:0]   fifo_empty;
  logic [NUM_SRC-1:0]   fifo_full;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic [NUM_SRC-1:0]   ovf;
  logic [SRC_W-1:0]     ovf_src;
  logic [DATA_W-1:0]    fifo_data [NUM_SRC];
  logic                 resp_valid;
  logic [DATA_W-1:0]    resp_data;
  logic [SRC_W-1:0]     resp_src;
  logic                 err_overflow;
  logic                 err_spurious;
  logic                 err_timeout;
  logic [SRC_W-1:0]     err_src;
  logic [TO_W-1:0]      tcnt;

  assign bus.req_ready_o = (outst < OUT_W'(MAX_OUTST));
  assign accept          = bus.req_valid_i & bus.req_ready_o;

  // Later (higher) regions override earlier ones, so the highest matching base wins.
  always_comb begin
    dec = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (bus.req_addr_i >= SRC_BASE[s]) dec = SRC_W'(s);
  end

  assign bus.src_req_valid_o = accept ? (NUM_SRC'(1) << dec) : '0;
  assign bus.src_req_addr_o  = bus.req_addr_i;

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!grant_vld && !fifo_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = SRC_W'(idx);
      end
    end
  end

  assign pop  = grant_vld ? (NUM_SRC'(1) << grant) : '0;
  assign push = bus.src_resp_valid_i & (~fifo_full | pop);
  assign ovf  = bus.src_resp_valid_i & fifo_full & ~pop;

  // Lowest overflowing source is reported when several overflow together.
  always_comb begin
    ovf_src = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--)
      if (ovf[s]) ovf_src = SRC_W'(s);
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    sim_refill_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .tb_clk    (tb_clk),
      .tb_rstn   (tb_rstn),
      .push      (push[g]),
      .push_data (bus.src_resp_data_i[g*DATA_W +: DATA_W]),
      .pop       (pop[g]),
      .pop_data  (fifo_data[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_src   <= '0;
      ptr        <= '0;
    end else if (grant_vld) begin
      resp_valid <= 1'b1;
      resp_data  <= fifo_data[grant];
      resp_src   <= grant;
      ptr        <= (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
    end else begin
      resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge tb_clk or negedge tb_rstn) begin
    if (!tb_rstn) begin
      outst        <= '0;
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
      err_src      <= '0;
      tcnt         <= '0;
    end else begin
      case ({accept, resp_valid})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   if (outst == '0) err_spurious <= 1'b1;
                 else outst <= outst - 1'b1;
        default: ;
      endcase
      if (|ovf) begin
        err_overflow <= 1'b1;
        if (!err_overflow) err_src <= ovf_src;
      end
      // Counter parks at TIMEOUT once the error has fired.
      if (TIMEOUT == 0 || outst == '0 || resp_valid) begin
        tcnt <= '0;
      end else if (tcnt != TO_W'(TIMEOUT)) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == TO_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
    end
  end

  assign bus.resp_valid_o   = resp_valid;
  assign bus.resp_data_o    = resp_data;
  assign bus.resp_src_o     = resp_src;
  assign bus.outst_o        = outst;
  assign bus.err_overflow_o = err_overflow;
  assign bus.err_spurious_o = err_spurious;
  assign bus.err_timeout_o  = err_timeout;
  assign bus.err_src_o      = err_src;

endmodule

// File: tb/tb_sim_refill_merger.sv
// Bench for sim_refill_merger: directed scenarios plus random traffic against a queue-based model.
module tb_sim_refill_merger;
  import sim_refill_pkg::*;

  localparam int        NSRC  = 2;
  localparam int        DEPTH = 2;
  localparam int        MAXO  = 4;
  localparam int        TOUT  = 16;
  localparam logic [39:0] L2_BASE = 40'h1_0000;

  logic tb_clk;
  logic tb_rstn;

  sim_refill_merger_if #(.NUM_SRC(NSRC), .ADDR_W(40), .DATA_W(128), .MAX_OUTST(MAXO)) bus ();

  sim_refill_merger #(
    .NUM_SRC    (NSRC),
    .ADDR_W     (40),
    .DATA_W     (128),
    .FIFO_DEPTH (DEPTH),
    .MAX_OUTST  (MAXO),
    .SRC_BASE   ({L2_BASE, 40'h0}),
    .TIMEOUT    (TOUT)
  ) dut (
    .tb_clk  (tb_clk),
    .tb_rstn (tb_rstn),
    .bus     (bus)
  );

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: one queue per source, round-robin pointer and plain counters.
  logic [127:0] q0[$];
  logic [127:0] q1[$];
  int           m_ptr, m_outst, m_tcnt, m_esrc, m_src;
  bit           m_rv, m_ovf, m_spur, m_to;
  logic [127:0] m_data;

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_ptr = 0; m_outst = 0; m_tcnt = 0; m_esrc = 0; m_src = 0;
    m_rv = 0; m_ovf = 0; m_spur = 0; m_to = 0; m_data = '0;
  endtask

  task automatic drive(input bit rv, input logic [39:0] addr, input logic [1:0] pv,
                       input logic [127:0] d1, input logic [127:0] d0);
    bus.req_valid_i      = rv;
    bus.req_addr_i       = addr;
    bus.src_resp_valid_i = pv;
    bus.src_resp_data_i  = {d1, d0};
  endtask

  task automatic idle();
    drive(1'b0, '0, 2'b00, '0, '0);
  endtask

  // Check combinational outputs, advance the model and the DUT one clock, check registered outputs.
  task automatic tick();
    bit           rdy, acc;
    logic [1:0]   pv, exp_srcv;
    logic [127:0] d;
    int           gnt;
    #1;
    pv       = bus.src_resp_valid_i;
    rdy      = (m_outst < MAXO);
    acc      = bus.req_valid_i && rdy;
    exp_srcv = !acc ? 2'b00 : (bus.req_addr_i >= L2_BASE) ? 2'b10 : 2'b01;
    chk("req_ready", bus.req_ready_o, rdy);
    chk("src_req_valid", bus.src_req_valid_o, exp_srcv);
    chk("src_req_addr", bus.src_req_addr_o, bus.req_addr_i);

    gnt = -1;
    if (m_ptr == 0) gnt = (q0.size() > 0) ? 0 : (q1.size() > 0) ? 1 : -1;
    else            gnt = (q1.size() > 0) ? 1 : (q0.size() > 0) ? 0 : -1;

    if (m_outst == 0 || m_rv) m_tcnt = 0;
    else if (m_tcnt < TOUT) begin
      m_tcnt++;
      if (m_tcnt == TOUT) m_to = 1;
    end
    if (acc && !m_rv) m_outst++;
    else if (!acc && m_rv) begin
      if (m_outst == 0) m_spur = 1;
      else m_outst--;
    end

    d = '0;
    if (gnt == 0) d = q0.pop_front();
    if (gnt == 1) d = q1.pop_front();
    if (pv[0]) begin
      if (q0.size() < DEPTH) q0.push_back(bus.src_resp_data_i[127:0]);
      else begin if (!m_ovf) m_esrc = 0; m_ovf = 1; end
    end
    if (pv[1]) begin
      if (q1.size() < DEPTH) q1.push_back(bus.src_resp_data_i[255:128]);
      else begin if (!m_ovf) m_esrc = 1; m_ovf = 1; end
    end
    m_rv = (gnt >= 0);
    if (m_rv) begin
      m_data = d;
      m_src  = gnt;
      m_ptr  = (gnt + 1) % NSRC;
    end

    @(posedge tb_clk);
    #1;
    chk("resp_valid", bus.resp_valid_o, m_rv);
    chk("resp_data", bus.resp_data_o, m_data);
    chk("resp_src", bus.resp_src_o, m_src);
    chk("outst", bus.outst_o, m_outst);
    chk("err_overflow", bus.err_overflow_o, m_ovf);
    chk("err_src", bus.err_src_o, m_esrc);
    chk("err_spurious", bus.err_spurious_o, m_spur);
    chk("err_timeout", bus.err_timeout_o, m_to);
  endtask

  task automatic do_reset();
    tb_rstn = 1'b0;
    drive(1'b0, '0, 2'b11, '1, '1);
    repeat (3) begin
      @(posedge tb_clk);
      #1;
      chk("rst_resp_valid", bus.resp_valid_o, 0);
      chk("rst_resp_data", bus.resp_data_o, 0);
      chk("rst_resp_src", bus.resp_src_o, 0);
      chk("rst_outst", bus.outst_o, 0);
      chk("rst_src_req_valid", bus.src_req_valid_o, 0);
      chk("rst_errs", {bus.err_overflow_o, bus.err_spurious_o, bus.err_timeout_o, bus.err_src_o}, 0);
    end
    tb_rstn = 1'b1;
    idle();
    model_reset();
  endtask

  initial begin
    tb_rstn = 1'b0;
    idle();
    model_reset();

    // Reset and quiet idle
    do_reset();
    tick();
    chk("idle_outst", bus.outst_o, 0);
    chk("idle_resp_valid", bus.resp_valid_o, 0);

    // Routing
    drive(1'b1, 40'h100, 2'b00, '0, '0); #1;
    chk("route_brom", bus.src_req_valid_o, 2'b01);
    tick();
    chk("route_brom_outst", bus.outst_o, 1);
    drive(1'b1, 40'h1_0040, 2'b00, '0, '0); #1;
    chk("route_l2", bus.src_req_valid_o, 2'b10);
    tick();
    chk("route_l2_outst", bus.outst_o, 2);

    // Latency
    drive(1'b0, '0, 2'b01, '0, 128'hA5);
    tick();
    chk("lat_t1_valid", bus.resp_valid_o, 0);
    idle();
    tick();
    chk("lat_t2_valid", bus.resp_valid_o, 1);
    chk("lat_t2_data", bus.resp_data_o, 128'hA5);
    chk("lat_t2_src", bus.resp_src_o, SRC_BROM);
    tick();
    chk("lat_outst", bus.outst_o, 1);

    // Arbitration with MAX_OUTST in flight
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i % 2) ? 40'h2_0000 : 40'h40, 2'b00, '0, '0);
      tick();
    end
    chk("arb_outst_full", bus.outst_o, 4);
    drive(1'b1, 40'h200, 2'b00, '0, '0); #1;
    chk("arb_fifth_ready", bus.req_ready_o, 0);
    tick();
    drive(1'b0, '0, 2'b11, 128'hD1A, 128'hD0A);
    tick();
    drive(1'b0, '0, 2'b11, 128'hD1B, 128'hD0B);
    tick();
    chk("arb_d0a", bus.resp_data_o, 128'hD0A);
    chk("arb_ready_at_first_resp", bus.req_ready_o, 0);
    idle();
    tick();
    chk("arb_d1a", bus.resp_data_o, 128'hD1A);
    chk("arb_d1a_src", bus.resp_src_o, SRC_L2);
    chk("arb_ready_after_resp", bus.req_ready_o, 1);
    tick();
    chk("arb_d0b", bus.resp_data_o, 128'hD0B);
    tick();
    chk("arb_d1b", bus.resp_data_o, 128'hD1B);
    chk("arb_d1b_valid", bus.resp_valid_o, 1);

    // Overflow on source 1 while arbitration alternates
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 40'h80, 2'b00, '0, '0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 2'b11, 128'h100 + i, 128'h200 + i);
      tick();
      if (i == 2) chk("ovf_third_ok", bus.err_overflow_o, 0);
    end
    chk("ovf_flag", bus.err_overflow_o, 1);
    chk("ovf_src", bus.err_src_o, 1);
    idle();
    repeat (6) tick();

    // Spurious response
    do_reset();
    drive(1'b0, '0, 2'b01, '0, 128'h55);
    tick();
    idle();
    tick();
    chk("spur_early", bus.err_spurious_o, 0);
    tick();
    chk("spur_set", bus.err_spurious_o, 1);

    // Timeout
    do_reset();
    drive(1'b1, 40'h100, 2'b00, '0, '0);
    tick();
    idle();
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("timeout_early", bus.err_timeout_o, 0);
      if (i == 16) chk("timeout_set", bus.err_timeout_o, 1);
    end

    // Random traffic, with one reset in the middle of it
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? {8'h0, $urandom} | 40'h1_0000 : {24'h0, 16'($urandom)},
            {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    idle();
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
